// File: rtl/dm_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dm_arbiter_pkg                                                   |
// | Brief   : Owner-state encoding and port identifiers for the dm arbiter.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } owner_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Counter width able to hold 0..max_burst inclusive.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dm_arbiter_if                                                    |
// | Brief   : Requester (cpu/dma) and data-memory signals of the dm arbiter.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              dm_MemWrite;
  logic              dm_MemRead;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_out;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  dm_out,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dm_MemWrite, dm_MemRead, dm_addr, dm_wdata
  );

  // Requesters plus data memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output dm_out,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dm_MemWrite, dm_MemRead, dm_addr, dm_wdata
  );

endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dm_arbiter                                                       |
// | Brief   : Round-robin, burst-bounded arbiter sharing the single-port data  |
// |           memory between the pipeline MEM stage and a DMA/debug loader.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  localparam int                CNT_W       = burst_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0]  C_MAX_BURST = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  C_ONE       = CNT_W'(1);

  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_burst_nxt;
  logic [CNT_W-1:0]  w_burst_inc;
  logic              w_burst_open;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;

  // Ungated pick feeds the registers; the reset gate is applied only on the way out.
  logic              w_cpu_pick;
  logic              w_dma_pick;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;
  logic [ADDR_W-1:0] w_dm_addr;
  logic [DATA_W-1:0] w_dm_wdata;

  assign w_burst_open = (r_burst_cnt < C_MAX_BURST);
  assign w_burst_inc  = (r_burst_cnt >= C_MAX_BURST) ? C_MAX_BURST : r_burst_cnt + C_ONE;

  // Grant decision and next owner/last/burst state.
  always_comb begin
    w_cpu_pick  = 1'b0;
    w_dma_pick  = 1'b0;
    w_owner_nxt = ST_IDLE;
    w_last_nxt  = r_last;
    w_burst_nxt = '0;

    case ({bus.cpu_req, bus.dma_req})
      2'b10: w_cpu_pick = 1'b1;
      2'b01: w_dma_pick = 1'b1;
      2'b11: begin
        case (r_owner)
          ST_CPU: begin
            w_cpu_pick = w_burst_open;
            w_dma_pick = ~w_burst_open;
          end
          ST_DMA: begin
            w_dma_pick = w_burst_open;
            w_cpu_pick = ~w_burst_open;
          end
          default: begin
            w_cpu_pick = (r_last == PORT_DMA);
            w_dma_pick = (r_last == PORT_CPU);
          end
        endcase
      end
      default: ;
    endcase

    if (w_cpu_pick) begin
      w_owner_nxt = ST_CPU;
      w_last_nxt  = PORT_CPU;
      w_burst_nxt = (r_owner == ST_CPU) ? w_burst_inc : C_ONE;
    end else if (w_dma_pick) begin
      w_owner_nxt = ST_DMA;
      w_last_nxt  = PORT_DMA;
      w_burst_nxt = (r_owner == ST_DMA) ? w_burst_inc : C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= ST_IDLE;
      r_last       <= PORT_DMA;
      r_burst_cnt  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_last       <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_cpu_rvalid <= w_cpu_pick & ~bus.cpu_we;
      r_dma_rvalid <= w_dma_pick & ~bus.dma_we;
    end
  end

  assign w_cpu_gnt = w_cpu_pick & ~rst;
  assign w_dma_gnt = w_dma_pick & ~rst;

  always_comb begin
    w_dm_addr  = '0;
    w_dm_wdata = '0;
    if (w_cpu_gnt) begin
      w_dm_addr  = bus.cpu_addr;
      w_dm_wdata = bus.cpu_wdata;
    end else if (w_dma_gnt) begin
      w_dm_addr  = bus.dma_addr;
      w_dm_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_gnt     = w_cpu_gnt;
  assign bus.dma_gnt     = w_dma_gnt;
  assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt & ~rst;
  assign bus.dm_MemWrite = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
  assign bus.dm_MemRead  = (w_cpu_gnt & ~bus.cpu_we) | (w_dma_gnt & ~bus.dma_we);
  assign bus.dm_addr     = w_dm_addr;
  assign bus.dm_wdata    = w_dm_wdata;

  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.dma_rvalid  = r_dma_rvalid;
  assign bus.cpu_rdata   = r_cpu_rvalid ? bus.dm_out : '0;
  assign bus.dma_rdata   = r_dma_rvalid ? bus.dm_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dm_arbiter                                                    |
// | Brief   : Directed + random scoreboard bench for dm_arbiter with a dm model.|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dm_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAXB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t         cq[$];
  rd_t         dq[$];
  logic [31:0] dm_mem[1024];
  logic [31:0] gold[1024];

  // Reference state: who was granted last cycle and how many grants in a row.
  int m_prev = -1;
  int m_run  = 0;
  int m_last = 1;
  int cwait  = 0;
  int dwait  = 0;
  bit cpu_took = 1'b0;
  bit dma_took = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Data memory: read data registered at the access edge.
  always @(posedge clk) begin
    if (bus.dm_MemWrite) dm_mem[bus.dm_addr[11:2]] = bus.dm_wdata;
    if (bus.dm_MemRead)  bus.dm_out <= dm_mem[bus.dm_addr[11:2]];
  end

  // Reference model: predicts grants and dm drive, pushes expected read data.
  always @(negedge clk) begin
    int e;
    bit cr, dr;
    if (rst) begin
      chk("rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("rst_dma_gnt", bus.dma_gnt, 0);
      chk("rst_cpu_stall", bus.cpu_stall, 0);
      chk("rst_memwrite", bus.dm_MemWrite, 0);
      chk("rst_memread", bus.dm_MemRead, 0);
      chk("rst_dm_addr", bus.dm_addr, 0);
      m_prev = -1; m_run = 0; m_last = 1;
      cwait = 0; dwait = 0; cpu_took = 0; dma_took = 0;
      cq.delete(); dq.delete();
    end else begin
      cr = bus.cpu_req;
      dr = bus.dma_req;
      if (cr && !dr)       e = 0;
      else if (dr && !cr)  e = 1;
      else if (!cr)        e = -1;
      else if (m_prev < 0) e = 1 - m_last;
      else if (m_run < MAXB) e = m_prev;
      else                 e = 1 - m_prev;

      chk("cpu_gnt", bus.cpu_gnt, (e == 0));
      chk("dma_gnt", bus.dma_gnt, (e == 1));
      chk("cpu_stall", bus.cpu_stall, (cr && e != 0));
      if (e == 0) begin
        chk("dm_memwrite", bus.dm_MemWrite, bus.cpu_we);
        chk("dm_memread", bus.dm_MemRead, !bus.cpu_we);
        chk("dm_addr", bus.dm_addr, bus.cpu_addr);
        chk("dm_wdata", bus.dm_wdata, bus.cpu_wdata);
      end else if (e == 1) begin
        chk("dm_memwrite", bus.dm_MemWrite, bus.dma_we);
        chk("dm_memread", bus.dm_MemRead, !bus.dma_we);
        chk("dm_addr", bus.dm_addr, bus.dma_addr);
        chk("dm_wdata", bus.dm_wdata, bus.dma_wdata);
      end else begin
        chk("dm_idle", {bus.dm_MemWrite, bus.dm_MemRead, bus.dm_addr, bus.dm_wdata}, 0);
      end

      if (e == 0) begin
        if (bus.cpu_we) gold[bus.cpu_addr[11:2]] = bus.cpu_wdata;
        else cq.push_back('{data: gold[bus.cpu_addr[11:2]], due: cyc + 1});
      end else if (e == 1) begin
        if (bus.dma_we) gold[bus.dma_addr[11:2]] = bus.dma_wdata;
        else dq.push_back('{data: gold[bus.dma_addr[11:2]], due: cyc + 1});
      end

      cwait = (cr && e != 0) ? cwait + 1 : 0;
      dwait = (dr && e != 1) ? dwait + 1 : 0;
      if (cr) chk("cpu_wait_bound", (cwait <= MAXB), 1);
      if (dr) chk("dma_wait_bound", (dwait <= MAXB), 1);

      if (e >= 0) begin
        m_run  = (e == m_prev) ? m_run + 1 : 1;
        m_prev = e;
        m_last = e;
      end else begin
        m_prev = -1;
        m_run  = 0;
      end
      cpu_took = (e == 0);
      dma_took = (e == 1);
    end
  end

  // Read-data monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    rd_t r;
    if (rst) begin
      chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    end else begin
      if (bus.cpu_rvalid) begin
        if (cq.size() == 0) chk("cpu_rvalid_unexpected", bus.cpu_rvalid, 0);
        else begin
          r = cq.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, r.data);
          chk("cpu_rvalid_latency", cyc, r.due);
        end
      end else begin
        chk("cpu_rdata_idle", bus.cpu_rdata, 0);
        if (cq.size() > 0 && cq[0].due <= cyc) begin
          chk("cpu_rvalid_missing", bus.cpu_rvalid, 1);
          void'(cq.pop_front());
        end
      end
      if (bus.dma_rvalid) begin
        if (dq.size() == 0) chk("dma_rvalid_unexpected", bus.dma_rvalid, 0);
        else begin
          r = dq.pop_front();
          chk("dma_rdata", bus.dma_rdata, r.data);
          chk("dma_rvalid_latency", cyc, r.due);
        end
      end else begin
        chk("dma_rdata_idle", bus.dma_rdata, 0);
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          chk("dma_rvalid_missing", bus.dma_rvalid, 1);
          void'(dq.pop_front());
        end
      end
    end
  end

  task automatic drive_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drive_dma(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm_mem[i] = init_word(i);
      gold[i]   = init_word(i);
    end
    drive_cpu(0, 0, 0, 0);
    drive_dma(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    next_cycle();
    rst = 1'b0;

    // cpu-only read, zero-wait grant, data next cycle
    drive_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    chk("t1_cpu_gnt", bus.cpu_gnt, 1);
    chk("t1_cpu_stall", bus.cpu_stall, 0);
    next_cycle();
    drive_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("t1_cpu_rdata", bus.cpu_rdata, init_word(4));

    // dma write followed by cpu read of the same word
    next_cycle();
    drive_dma(1, 1, 32'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_dma_gnt", bus.dma_gnt, 1);
    next_cycle();
    drive_dma(0, 0, 0, 0);
    drive_cpu(1, 0, 32'h20, 0);
    @(negedge clk);
    chk("t2_cpu_gnt", bus.cpu_gnt, 1);
    next_cycle();
    drive_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);

    // tie from reset, then sustained contention: CCCCDDDDCCCC...
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    drive_cpu(1, $urandom_range(0, 1), rand_addr(), $urandom);
    drive_dma(1, $urandom_range(0, 1), rand_addr(), $urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t4_cpu_pattern", bus.cpu_gnt, ((k / MAXB) % 2 == 0));
      chk("t4_dma_pattern", bus.dma_gnt, ((k / MAXB) % 2 == 1));
      if (k == MAXB) chk("t3_cpu_stall_on_switch", bus.cpu_stall, 1);
      next_cycle();
      if (cpu_took) drive_cpu(1, $urandom_range(0, 1), rand_addr(), $urandom);
      if (dma_took) drive_dma(1, $urandom_range(0, 1), rand_addr(), $urandom);
    end
    drive_cpu(0, 0, 0, 0);
    drive_dma(0, 0, 0, 0);

    // reset in the middle of a dma write burst with a cpu read in flight
    next_cycle();
    drive_dma(1, 1, 32'h40, 32'h1111_1111);
    @(negedge clk);
    next_cycle();
    drive_dma(1, 1, 32'h44, 32'h2222_2222);
    @(negedge clk);
    next_cycle();
    drive_dma(0, 0, 0, 0);
    drive_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    drive_cpu(1, 0, 32'h50, 0);
    drive_dma(1, 1, 32'h50, 32'hBAD0_0BAD);
    @(negedge clk);
    chk("t5_rvalid_cleared", bus.cpu_rvalid, 0);
    chk("t5_dma_gnt", bus.dma_gnt, 0);
    chk("t5_memwrite", bus.dm_MemWrite, 0);
    next_cycle();
    rst = 1'b0;
    drive_dma(1, 1, 32'h60, 32'h3333_3333);
    @(negedge clk);
    chk("t5_tie_cpu_gnt", bus.cpu_gnt, 1);
    chk("t5_tie_dma_gnt", bus.dma_gnt, 0);
    next_cycle();
    drive_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_word_unchanged", bus.cpu_rdata, init_word(20));
    next_cycle();
    drive_dma(0, 0, 0, 0);

    // idle gap after a cpu grant: tie then goes to dma, burst restarts at 1
    drive_cpu(1, 1, 32'h8, 32'h4444_4444);
    @(negedge clk);
    next_cycle();
    drive_cpu(0, 0, 0, 0);
    repeat (2) next_cycle();
    drive_cpu(1, $urandom_range(0, 1), rand_addr(), $urandom);
    drive_dma(1, $urandom_range(0, 1), rand_addr(), $urandom);
    for (int k = 0; k < 2 * MAXB; k++) begin
      @(negedge clk);
      chk("t6_dma_pattern", bus.dma_gnt, (k < MAXB));
      next_cycle();
      if (cpu_took) drive_cpu(1, $urandom_range(0, 1), rand_addr(), $urandom);
      if (dma_took) drive_dma(1, $urandom_range(0, 1), rand_addr(), $urandom);
    end

    // random traffic; requests are held until granted
    for (int n = 0; n < 600; n++) begin
      if (!bus.cpu_req || cpu_took)
        drive_cpu($urandom_range(0, 99) < 55, $urandom_range(0, 1), rand_addr(), $urandom);
      if (!bus.dma_req || dma_took)
        drive_dma($urandom_range(0, 99) < 55, $urandom_range(0, 1), rand_addr(), $urandom);
      @(negedge clk);
      next_cycle();
    end
    drive_cpu(0, 0, 0, 0);
    drive_dma(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("cpu_queue_drained", cq.size(), 0);
    chk("dma_queue_drained", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
